bp_cache: RTL and testbench
===========================

BP_CACHE -- requirements
Module: bp_cache

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, address width in bits.
REQ-002 SHALL have parameter DWIDTH, default 32, data width in bits.
REQ-003 SHALL have parameter LINES, default 128, number of entries; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1 bit; the single clock, all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-006 SHALL have port ra0, input, AWIDTH bits; read address for port 0.
REQ-007 SHALL have port dout0, output, DWIDTH bits; read data for port 0.
REQ-008 SHALL have port hit0, output, 1 bit; port 0 lookup hit.
REQ-009 SHALL have port ra1, input, AWIDTH bits; read address for port 1.
REQ-010 SHALL have port dout1, output, DWIDTH bits; read data for port 1.
REQ-011 SHALL have port hit1, output, 1 bit; port 1 lookup hit.
REQ-012 SHALL have port wa, input, AWIDTH bits; write address.
REQ-013 SHALL have port din, input, DWIDTH bits; write data.
REQ-014 SHALL have port we, input, 1 bit; write enable.

Function
REQ-015 SHALL be a direct-mapped store of LINES entries, each holding a valid bit, a tag and DWIDTH data bits.
REQ-016 SHALL ignore address bits [1:0]; with IB = log2(LINES), index = addr[IB+1:2] and tag = addr[AWIDTH-1:IB+2]. For the defaults, IB = 7, index = addr[8:2] and tag = addr[31:9].
REQ-017 Reads SHALL be combinational, with zero latency: hitN = valid[idx(raN)] AND tag[idx(raN)] == tag(raN).
REQ-018 doutN SHALL equal the stored data when hitN = 1, and SHALL be all zeros when hitN = 0.
REQ-019 The two read ports SHALL be fully independent; identical or conflicting addresses on ra0 and ra1 SHALL both resolve correctly in the same cycle.
REQ-020 When we = 1 at a rising clk edge and reset = 0, the entry at idx(wa) SHALL load tag(wa) and din and set valid = 1.
REQ-021 A write SHALL unconditionally replace the existing entry at that index; no replacement policy beyond direct mapping is required.
REQ-022 Write-to-read forwarding: while we = 1 and raN matches wa in both index and tag, hitN SHALL be 1 and doutN SHALL equal din in the same cycle, on each port independently.
REQ-023 When we = 1 and raN has the same index as wa but a different tag, port N SHALL report the stored (pre-write) entry contents.
REQ-024 After a write edge, reads of that address SHALL hit with the new data starting on the next cycle.
REQ-025 Two addresses that share an index but differ in tag SHALL alias: writing one evicts the other, and the evicted address then misses.

Reset
REQ-026 reset = 1 at a rising clk edge SHALL clear every valid bit; tag and data contents need not be cleared.
REQ-027 reset SHALL take priority over we; a write presented in the same cycle as reset SHALL be discarded.
REQ-028 While all entries are invalid, hit0 and hit1 SHALL be 0 and dout0 and dout1 SHALL be 0, except when REQ-022 forwarding applies with reset = 0.
REQ-029 Asserting reset in the middle of a sequence of writes SHALL invalidate all prior entries; writes resume normally on the first cycle with reset = 0.

Verification
REQ-030 Reset, then write 0x10<-DEADBEEF, 0x20<-CAFEBABE, 0x30<-12345678, then set we = 0 -> reading ra0 = 0x10 and ra1 = 0x20 gives hit0 = hit1 = 1, dout0 = DEADBEEF, dout1 = CAFEBABE; reading ra0 = 0x30 and ra1 = 0x10 gives 12345678 and DEADBEEF.
REQ-031 After REQ-030, read ra0 = 0x40, ra1 = 0x50, and then 0x60/0x70 and 0x80/0x90 -> hit0 = hit1 = 0 and dout0 = dout1 = 0 in every case.
REQ-032 After REQ-030, write 0x210<-AAAA5555 (index 4, tag 1), then read 0x10 and 0x210 -> 0x10 misses; 0x210 hits with AAAA5555.
REQ-033 Hold we = 1, wa = 0x44, din = 0x0BADF00D, ra0 = 0x44 -> hit0 = 1 and dout0 = 0x0BADF00D in the same cycle, before the clock edge.
REQ-034 Reading ra0 = 0x13 after 0x10 has been written -> hit0 = 1 with the 0x10 data, confirming bits [1:0] are ignored.
REQ-035 Assert reset together with we = 1, wa = 0x20 -> afterwards 0x10, 0x20 and 0x30 all miss.

Source files
------------

// File: rtl/bp_cache.sv
// Direct-mapped store with two independent combinational read ports and one write port.
// Reads are zero-latency with same-cycle write forwarding; no backpressure, a write is accepted every cycle.
module bp_cache #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int LINES  = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] ra0,
  output logic [DWIDTH-1:0] dout0,
  output logic              hit0,
  input  logic [AWIDTH-1:0] ra1,
  output logic [DWIDTH-1:0] dout1,
  output logic              hit1,
  input  logic [AWIDTH-1:0] wa,
  input  logic [DWIDTH-1:0] din,
  input  logic              we
);

  localparam int IB = $clog2(LINES);
  localparam int TW = AWIDTH - IB - 2;

  logic [LINES-1:0]  valid;
  logic [TW-1:0]     tag_mem  [LINES];
  logic [DWIDTH-1:0] data_mem [LINES];

  logic [IB-1:0] widx;
  logic [TW-1:0] wtag;
  logic          wr_en;

  // Byte-offset bits never take part in a lookup.
  logic unused_offset;
  assign unused_offset = ^{ra0[1:0], ra1[1:0], wa[1:0]};

  assign widx  = wa[IB+1:2];
  assign wtag  = wa[AWIDTH-1:IB+2];
  assign wr_en = we && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else if (we) begin
      valid[widx] <= 1'b1;
    end
  end

  // Tag and data arrays are not cleared by reset; the valid bits gate them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[widx]  <= wtag;
      data_mem[widx] <= din;
    end
  end

  logic [IB-1:0] idx0, idx1;
  logic [TW-1:0] tag0, tag1;
  logic          stored_hit0, stored_hit1;
  logic          fwd0, fwd1;

  assign idx0 = ra0[IB+1:2];
  assign tag0 = ra0[AWIDTH-1:IB+2];
  assign idx1 = ra1[IB+1:2];
  assign tag1 = ra1[AWIDTH-1:IB+2];

  assign stored_hit0 = valid[idx0] && (tag_mem[idx0] == tag0);
  assign stored_hit1 = valid[idx1] && (tag_mem[idx1] == tag1);

  // Forwarding needs a full index+tag match; a same-index, different-tag read sees the old entry.
  assign fwd0 = wr_en && (ra0[AWIDTH-1:2] == wa[AWIDTH-1:2]);
  assign fwd1 = wr_en && (ra1[AWIDTH-1:2] == wa[AWIDTH-1:2]);

  always_comb begin
    hit0  = 1'b0;
    dout0 = '0;
    if (fwd0) begin
      hit0  = 1'b1;
      dout0 = din;
    end else if (stored_hit0) begin
      hit0  = 1'b1;
      dout0 = data_mem[idx0];
    end
  end

  always_comb begin
    hit1  = 1'b0;
    dout1 = '0;
    if (fwd1) begin
      hit1  = 1'b1;
      dout1 = din;
    end else if (stored_hit1) begin
      hit1  = 1'b1;
      dout1 = data_mem[idx1];
    end
  end

endmodule

// File: tb/tb_bp_cache.sv
// Directed and randomized checks of bp_cache against an address-keyed reference model.
module tb_bp_cache;

  localparam int LINES = 128;

  logic        clk;
  logic        reset;
  logic [31:0] ra0, ra1, wa, din;
  logic        we;
  logic [31:0] dout0, dout1;
  logic        hit0, hit1;

  int tests = 0;
  int fails = 0;

  // Model: one slot per line index holding the word address and data last written there.
  logic [29:0] m_word [int];
  logic [31:0] m_data [int];

  bp_cache #(.AWIDTH(32), .DWIDTH(32), .LINES(LINES)) dut (
    .clk(clk), .reset(reset),
    .ra0(ra0), .dout0(dout0), .hit0(hit0),
    .ra1(ra1), .dout1(dout1), .hit1(hit1),
    .wa(wa), .din(din), .we(we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic void model_read(input logic [31:0] a, output logic h, output logic [31:0] d);
    int i;
    i = int'((a >> 2) % LINES);
    h = 1'b0;
    d = 32'h0;
    if (we && !reset && (a >> 2) == (wa >> 2)) begin
      h = 1'b1;
      d = din;
    end else if (m_word.exists(i) && m_word[i] == a[31:2]) begin
      h = 1'b1;
      d = m_data[i];
    end
  endfunction

  task automatic check_model(input string name);
    logic        h;
    logic [31:0] d;
    model_read(ra0, h, d);
    cmp({name, ".hit0"}, {31'h0, hit0}, {31'h0, h});
    cmp({name, ".dout0"}, dout0, d);
    model_read(ra1, h, d);
    cmp({name, ".hit1"}, {31'h0, hit1}, {31'h0, h});
    cmp({name, ".dout1"}, dout1, d);
  endtask

  task automatic chk4(input string name, input logic h0, input logic [31:0] d0,
                      input logic h1, input logic [31:0] d1);
    cmp({name, ".hit0"}, {31'h0, hit0}, {31'h0, h0});
    cmp({name, ".dout0"}, dout0, d0);
    cmp({name, ".hit1"}, {31'h0, hit1}, {31'h0, h1});
    cmp({name, ".dout1"}, dout1, d1);
  endtask

  task automatic tick();
    int i;
    @(posedge clk);
    i = int'((wa >> 2) % LINES);
    if (reset) begin
      m_word.delete();
      m_data.delete();
    end else if (we) begin
      m_word[i] = wa[31:2];
      m_data[i] = din;
    end
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; din = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a0, input logic [31:0] a1);
    ra0 = a0; ra1 = a1;
    #1;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; wa = '0; din = '0; ra0 = '0; ra1 = '0;
    #1;
    tick();
    tick();
    reset = 1'b0;

    rd(32'h10, 32'h20);
    chk4("reset_state", 1'b0, 32'h0, 1'b0, 32'h0);

    wr(32'h10, 32'hDEADBEEF);
    wr(32'h20, 32'hCAFEBABE);
    wr(32'h30, 32'h12345678);
    rd(32'h10, 32'h20);
    chk4("basic_10_20", 1'b1, 32'hDEADBEEF, 1'b1, 32'hCAFEBABE);
    rd(32'h30, 32'h10);
    chk4("basic_30_10", 1'b1, 32'h12345678, 1'b1, 32'hDEADBEEF);
    rd(32'h10, 32'h10);
    chk4("same_addr_both", 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);

    rd(32'h13, 32'h22);
    chk4("offset_ignored", 1'b1, 32'hDEADBEEF, 1'b1, 32'hCAFEBABE);

    rd(32'h40, 32'h50);
    chk4("miss_40_50", 1'b0, 32'h0, 1'b0, 32'h0);
    rd(32'h60, 32'h70);
    chk4("miss_60_70", 1'b0, 32'h0, 1'b0, 32'h0);
    rd(32'h80, 32'h90);
    chk4("miss_80_90", 1'b0, 32'h0, 1'b0, 32'h0);

    wr(32'h210, 32'hAAAA5555);
    rd(32'h10, 32'h210);
    chk4("alias_evict", 1'b0, 32'h0, 1'b1, 32'hAAAA5555);

    // Same index, different tag while writing: port shows the pre-write entry.
    we = 1'b1; wa = 32'h10; din = 32'h11112222;
    rd(32'h210, 32'h10);
    chk4("same_idx_prewrite", 1'b1, 32'hAAAA5555, 1'b1, 32'h11112222);
    tick();
    we = 1'b0;
    rd(32'h210, 32'h10);
    chk4("after_rewrite", 1'b0, 32'h0, 1'b1, 32'h11112222);

    we = 1'b1; wa = 32'h44; din = 32'h0BADF00D;
    rd(32'h44, 32'h20);
    chk4("forward_44", 1'b1, 32'h0BADF00D, 1'b1, 32'hCAFEBABE);
    tick();
    we = 1'b0;
    rd(32'h20, 32'h44);
    chk4("written_44", 1'b1, 32'hCAFEBABE, 1'b1, 32'h0BADF00D);

    reset = 1'b1; we = 1'b1; wa = 32'h20; din = 32'h55555555;
    tick();
    reset = 1'b0; we = 1'b0;
    rd(32'h10, 32'h20);
    chk4("reset_vs_we_a", 1'b0, 32'h0, 1'b0, 32'h0);
    rd(32'h30, 32'h44);
    chk4("reset_vs_we_b", 1'b0, 32'h0, 1'b0, 32'h0);

    wr(32'h30, 32'h76543210);
    rd(32'h30, 32'h31);
    chk4("resume_after_reset", 1'b1, 32'h76543210, 1'b1, 32'h76543210);

    // Small address pool so aliasing, hits and forwarding all occur often.
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      we    = $urandom_range(0, 1);
      wa    = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      din   = $urandom;
      ra0   = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      ra1   = ($urandom_range(0, 3) == 0) ? wa :
              (($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      #1;
      if (!reset) check_model("random");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
